d_inst_queue: RTL
=================

// Module: d_inst_queue
// PURPOSE
//  Parametrised decode-side instruction queue between F and D. Buffers up to DEPTH
//  fetched words, classifies each on enqueue (fetch-exc passthrough, Syscall, RI),
//  tags branches and delay slots, presents the head entry to the D stage.
//  Decouples fetch from D-stage stalls; flush on exception/eret empties it.
// PARAMETERS
//  DEPTH   4   queue entries, power of two, >=2
//  PTR_W   2   log2(DEPTH)
//  XLEN    32  PC/instruction width
//  EXC_W   5   ExcCode width
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low reset
//  flush        in   1       drop all entries (exception/eret redirect)
//  enq_valid    in   1       F presents a word
//  enq_ready    out  1       queue can accept (= !full)
//  enq_pc       in   XLEN    PC of word
//  enq_instr    in   XLEN    raw instruction
//  enq_exccode  in   EXC_W   fetch ExcCode (AdEL etc.), 0 = None
//  deq_valid    out  1       head entry valid (= !empty)
//  deq_ready    in   1       D stage consumes head this cycle
//  deq_pc       out  XLEN    head PC
//  deq_instr    out  XLEN    head instruction; 0 if entry carries any exception
//  deq_exccode  out  EXC_W   head ExcCode
//  deq_is_delay out  1       head is a branch delay slot
//  deq_is_branch out 1       head is beq/bne/jal/jr
//  count        out  PTR_W+1 occupied entries
// BEHAVIOUR
//  - Reset (async, reset==0): rd/wr ptrs 0, count 0, prev_branch 0, storage 0;
//    all deq_* outputs 0, enq_ready 1, deq_valid 0.
//  - Enqueue fires when enq_valid && enq_ready; dequeue when deq_valid && deq_ready.
//    Both may fire in one cycle (count unchanged). enq_ready is registered-state
//    only (!full); no same-cycle full-slot reuse, no comb path deq_ready->enq_ready.
//  - Latency: written entry visible at head the cycle after enqueue; no bypass
//    when empty. Outputs are a mux of storage at rd_ptr (no extra register stage).
//  - Pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0.
//  - Classification on enqueue, stored with entry:
//    exccode = enq_exccode!=0 ? enq_exccode : syscall ? 8 (Syscall)
//              : illegal ? 10 (RI) : 0. Fetch code has strict priority.
//    legal set: SPECIAL add sub and or slt sltu jr syscall mult multu div divu
//    mfhi mflo mthi mtlo; ori andi addi lui lw lh lb sw sh sb beq bne jal;
//    COP0 mfc0 mtc0 eret; all-zero word. Anything else -> RI.
//    instr stored as 0 when exccode!=0; is_branch = beq|bne|jal|jr (only when exccode==0).
//  - Delay-slot tag: prev_branch register = is_branch of last enqueued entry;
//    each enqueued entry gets is_delay = prev_branch. Updated only on enqueue.
//  - flush: highest priority. Same-cycle enq and deq are discarded; next cycle
//    count 0, ptrs 0, prev_branch 0, deq_valid 0, enq_ready 1.
//  - Dequeue from empty / enqueue into full: no effect on state.
//  - Reset mid-operation: immediate return to reset state, contents lost.
// STRUCTURE
//  - ExcCode values (None=0, Syscall=8, RI=10), opcode/funct/rs constants live in
//    shared define.v; no new typedefs.
//  - One combinational sub-module d_inst_classify(instr, fetch_exc -> exccode,
//    is_branch, instr_out); queue storage, pointers, prev_branch in this module.
// TESTING
//  - Reset then idle: count=0, deq_valid=0, enq_ready=1, deq_* all 0.
//  - Enqueue ori 0x34210001 @PC 0x3000 -> next cycle deq_valid=1, deq_pc=0x3000,
//    deq_exccode=0, deq_is_branch=0, deq_is_delay=0.
//  - Enqueue beq 0x10000002 then nop 0 -> 2nd entry is_delay=1, 1st is_branch=1.
//  - Enqueue 0xFC000000 -> deq_exccode=10, deq_instr=0; enqueue 0x0000000C with
//    enq_exccode=4 -> deq_exccode=4 (fetch priority over Syscall).
//  - deq_ready=0, push 5 words (DEPTH=4): 5th held, enq_ready=0 at count=4;
//    then simultaneous enq+deq at count=3 keeps count=3, order preserved across wrap.
//  - count=3 with enq_valid=deq_ready=1 and flush=1 -> next cycle count=0,
//    deq_valid=0; next enqueue after beq-flush gets is_delay=0.

Source files
------------

// File: rtl/d_inst_queue_pkg.sv
// Shared ExcCodes and MIPS opcode/funct/rs field constants for the decode-side
// instruction queue, plus the legal-instruction check used by the classifier.
package d_inst_queue_pkg;

    localparam int EXC_NONE    = 0;
    localparam int EXC_SYSCALL = 8;
    localparam int EXC_RI      = 10;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_COP0    = 6'h10;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1A;
    localparam logic [5:0] FN_DIVU    = 6'h1B;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;
    localparam logic [5:0] FN_ERET    = 6'h18;

    localparam logic [4:0] RS_MF      = 5'h00;
    localparam logic [4:0] RS_MT      = 5'h04;
    localparam logic [4:0] RS_CO      = 5'h10;

    function automatic logic legal_instr(input logic [31:0] instr);
        logic [5:0] opcode;
        logic [5:0] funct;
        logic [4:0] rs;
        opcode = instr[31:26];
        funct  = instr[5:0];
        rs     = instr[25:21];
        legal_instr = 1'b0;
        if (instr == 32'h0) begin
            legal_instr = 1'b1;
        end else begin
            case (opcode)
                OP_SPECIAL: begin
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLTU, FN_JR,
                        FN_SYSCALL, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                        FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO: legal_instr = 1'b1;
                        default:                            legal_instr = 1'b0;
                    endcase
                end
                OP_ORI, OP_ANDI, OP_ADDI, OP_LUI, OP_LW, OP_LH, OP_LB,
                OP_SW, OP_SH, OP_SB, OP_BEQ, OP_BNE, OP_JAL: legal_instr = 1'b1;
                OP_COP0: legal_instr = (rs == RS_MF) || (rs == RS_MT) ||
                                       ((rs == RS_CO) && (funct == FN_ERET));
                default: legal_instr = 1'b0;
            endcase
        end
    endfunction

endpackage

// File: rtl/d_inst_queue_classify.sv
// Enqueue-side classifier: folds fetch exceptions, Syscall and reserved
// instructions into one ExcCode and flags branches on clean words.
module d_inst_classify
    import d_inst_queue_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int EXC_W = 5
) (
    input  logic [XLEN-1:0]  instr,
    input  logic [EXC_W-1:0] fetch_exc,
    output logic [EXC_W-1:0] exccode,
    output logic             is_branch,
    output logic [XLEN-1:0]  instr_out
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_syscall;
    logic       is_br_op;

    always_comb begin
        opcode     = instr[31:26];
        funct      = instr[5:0];
        is_syscall = (opcode == OP_SPECIAL) && (funct == FN_SYSCALL);
        is_br_op   = (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_JAL) ||
                     ((opcode == OP_SPECIAL) && (funct == FN_JR));

        // Fetch faults win over anything decoded from the (possibly bogus) word.
        if (fetch_exc != '0)
            exccode = fetch_exc;
        else if (is_syscall)
            exccode = EXC_W'(EXC_SYSCALL);
        else if (!legal_instr(instr[31:0]))
            exccode = EXC_W'(EXC_RI);
        else
            exccode = EXC_W'(EXC_NONE);

        is_branch = (exccode == '0) && is_br_op;
        instr_out = (exccode == '0) ? instr : '0;
    end

endmodule

// File: rtl/d_inst_queue.sv
// Decode-side instruction FIFO between F and D: stores classified fetch words and
// presents the head entry combinationally from storage.
module d_inst_queue
    import d_inst_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2,
    parameter int XLEN  = 32,
    parameter int EXC_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [XLEN-1:0]  enq_pc,
    input  logic [XLEN-1:0]  enq_instr,
    input  logic [EXC_W-1:0] enq_exccode,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [XLEN-1:0]  deq_pc,
    output logic [XLEN-1:0]  deq_instr,
    output logic [EXC_W-1:0] deq_exccode,
    output logic             deq_is_delay,
    output logic             deq_is_branch,
    output logic [PTR_W:0]   count
);

    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             prev_branch_reg;

    logic [XLEN-1:0]  pc_mem     [DEPTH];
    logic [XLEN-1:0]  instr_mem  [DEPTH];
    logic [EXC_W-1:0] exc_mem    [DEPTH];
    logic             delay_mem  [DEPTH];
    logic             branch_mem [DEPTH];

    logic [EXC_W-1:0] cls_exccode;
    logic             cls_branch;
    logic [XLEN-1:0]  cls_instr;
    logic             enq_fire;
    logic             deq_fire;

    d_inst_classify #(.XLEN(XLEN), .EXC_W(EXC_W)) u_classify (
        .instr     (enq_instr),
        .fetch_exc (enq_exccode),
        .exccode   (cls_exccode),
        .is_branch (cls_branch),
        .instr_out (cls_instr)
    );

    assign enq_ready = (count_reg != (PTR_W+1)'(DEPTH));
    assign deq_valid = (count_reg != '0);
    assign enq_fire  = enq_valid && enq_ready && !flush;
    assign deq_fire  = deq_valid && deq_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            prev_branch_reg <= 1'b0;
        end else if (flush) begin
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            prev_branch_reg <= 1'b0;
        end else begin
            if (enq_fire) begin
                wr_ptr_reg      <= wr_ptr_reg + 1'b1;
                prev_branch_reg <= cls_branch;
            end
            if (deq_fire)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(deq_fire);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pc_mem[gi]     <= '0;
                    instr_mem[gi]  <= '0;
                    exc_mem[gi]    <= '0;
                    delay_mem[gi]  <= 1'b0;
                    branch_mem[gi] <= 1'b0;
                end else if (enq_fire && (wr_ptr_reg == PTR_W'(gi))) begin
                    pc_mem[gi]     <= enq_pc;
                    instr_mem[gi]  <= cls_instr;
                    exc_mem[gi]    <= cls_exccode;
                    delay_mem[gi]  <= prev_branch_reg;
                    branch_mem[gi] <= cls_branch;
                end
            end
        end
    endgenerate

    assign deq_pc        = pc_mem[rd_ptr_reg];
    assign deq_instr     = instr_mem[rd_ptr_reg];
    assign deq_exccode   = exc_mem[rd_ptr_reg];
    assign deq_is_delay  = delay_mem[rd_ptr_reg];
    assign deq_is_branch = branch_mem[rd_ptr_reg];
    assign count         = count_reg;

endmodule
